// File: rtl/fetch_stage_btb.sv
// Fetch stage: registered PC, with same-cycle next-PC prediction from a direct-mapped BTB and 2-bit counters.
// Stalls hold the PC. A redirect from execute overrides a stall, and BTB training runs independently of both.
module fetch_stage_btb #(
   parameter int              XLEN        = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clock,
   input  logic            async_reset,
   input  logic            enable_fetch,
   input  logic            redirect_E,
   input  logic [XLEN-1:0] redirect_pc_E,
   input  logic            update_valid_E,
   input  logic [XLEN-1:0] update_pc_E,
   input  logic [XLEN-1:0] update_target_E,
   input  logic            update_taken_E,
   output logic [XLEN-1:0] PC_F,
   output logic [XLEN-1:0] PC_plus_4_F,
   output logic            pred_taken_F,
   output logic [XLEN-1:0] pred_target_F
);
   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int TAGW = XLEN - IDX - 2;

   logic            btb_valid  [BTB_ENTRIES];
   logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0] btb_target [BTB_ENTRIES];
   logic [1:0]      btb_ctr    [BTB_ENTRIES];

   logic [IDX-1:0]  f_idx;
   logic [IDX-1:0]  u_idx;
   logic [TAGW-1:0] f_tag;
   logic [TAGW-1:0] u_tag;
   logic            f_hit;
   logic            u_hit;
   logic            unused_low_bits;

   // Instruction addresses are word aligned, so the byte offset never selects anything.
   assign unused_low_bits = ^update_pc_E[1:0];

   assign f_idx = PC_F[IDX+1:2];
   assign f_tag = PC_F[XLEN-1:IDX+2];
   assign u_idx = update_pc_E[IDX+1:2];
   assign u_tag = update_pc_E[XLEN-1:IDX+2];

   assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

   assign PC_plus_4_F   = PC_F + XLEN'(4);
   assign pred_taken_F  = f_hit && btb_ctr[f_idx][1];
   assign pred_target_F = pred_taken_F ? btb_target[f_idx] : PC_plus_4_F;

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         PC_F <= RESET_PC;
      end else if (redirect_E) begin
         PC_F <= redirect_pc_E;
      end else if (enable_fetch) begin
         PC_F <= pred_target_F;
      end
   end

   // Lookup above reads the current array contents, so a same-index update is seen from the next cycle on.
   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'b01;
         end
      end else if (update_valid_E) begin
         if (u_hit) begin
            if (update_taken_E) begin
               btb_ctr[u_idx]    <= (btb_ctr[u_idx] == 2'b11) ? 2'b11 : btb_ctr[u_idx] + 2'd1;
               btb_target[u_idx] <= update_target_E;
            end else begin
               btb_ctr[u_idx] <= (btb_ctr[u_idx] == 2'b00) ? 2'b00 : btb_ctr[u_idx] - 2'd1;
            end
         end else if (update_taken_E) begin
            btb_valid[u_idx]  <= 1'b1;
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= update_target_E;
            btb_ctr[u_idx]    <= 2'b10;
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage_btb.sv
// Directed bench for fetch_stage_btb: reset, sequential fetch, BTB allocation/training, aliasing,
// stall vs redirect, wrap-around and asynchronous reset, all against hand-computed values.
module tb_fetch_stage_btb;
   logic        clock = 1'b0;
   logic        async_reset;
   logic        enable_fetch;
   logic        redirect_E;
   logic [31:0] redirect_pc_E;
   logic        update_valid_E;
   logic [31:0] update_pc_E;
   logic [31:0] update_target_E;
   logic        update_taken_E;
   logic [31:0] PC_F;
   logic [31:0] PC_plus_4_F;
   logic        pred_taken_F;
   logic [31:0] pred_target_F;

   int checks = 0;
   int errors = 0;

   fetch_stage_btb #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
      .clock          (clock),
      .async_reset    (async_reset),
      .enable_fetch   (enable_fetch),
      .redirect_E     (redirect_E),
      .redirect_pc_E  (redirect_pc_E),
      .update_valid_E (update_valid_E),
      .update_pc_E    (update_pc_E),
      .update_target_E(update_target_E),
      .update_taken_E (update_taken_E),
      .PC_F           (PC_F),
      .PC_plus_4_F    (PC_plus_4_F),
      .pred_taken_F   (pred_taken_F),
      .pred_target_F  (pred_target_F)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      redirect_E     = 1'b0;
      update_valid_E = 1'b0;
      update_taken_E = 1'b0;
   endtask

   task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
      update_valid_E  = 1'b1;
      update_pc_E     = pc;
      update_target_E = tgt;
      update_taken_E  = taken;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_E    = 1'b1;
      redirect_pc_E = pc;
   endtask

   initial begin
      async_reset     = 1'b0;
      enable_fetch    = 1'b0;
      redirect_pc_E   = '0;
      update_pc_E     = '0;
      update_target_E = '0;
      idle_inputs();

      // Reset state
      step(); step();
      check("reset_pc", PC_F, 32'h0);
      check("reset_taken", {31'b0, pred_taken_F}, 32'h0);
      check("reset_target", pred_target_F, 32'h4);

      // Sequential fetch after release
      async_reset  = 1'b1;
      enable_fetch = 1'b1;
      step(); check("seq_pc_4", PC_F, 32'h4);
      step(); check("seq_pc_8", PC_F, 32'h8);
      step(); check("seq_pc_12", PC_F, 32'hC);
      check("seq_taken", {31'b0, pred_taken_F}, 32'h0);
      check("seq_plus4", PC_plus_4_F, 32'h10);

      // Allocate 0x40 -> 0x100 while redirecting to 0x40 in the same cycle
      train(32'h40, 32'h100, 1'b1);
      redirect(32'h40);
      step(); idle_inputs();
      check("alloc_pc", PC_F, 32'h40);
      check("alloc_taken", {31'b0, pred_taken_F}, 32'h1);
      check("alloc_target", pred_target_F, 32'h100);
      step();
      check("follow_pred_pc", PC_F, 32'h100);
      // 0x100 shares index 0 with 0x40 but has a different tag
      check("alias100_taken", {31'b0, pred_taken_F}, 32'h0);
      check("alias100_target", pred_target_F, 32'h104);

      // Counter hysteresis at 0x40 while stalled
      enable_fetch = 1'b0;
      redirect(32'h40);
      train(32'h40, 32'h100, 1'b0);
      step(); idle_inputs();
      check("nt_ctr01_taken", {31'b0, pred_taken_F}, 32'h0);
      check("nt_ctr01_target", pred_target_F, 32'h44);
      train(32'h40, 32'h100, 1'b1);
      step();
      check("t_ctr10_taken", {31'b0, pred_taken_F}, 32'h1);
      step();
      check("t_ctr11_taken", {31'b0, pred_taken_F}, 32'h1);
      train(32'h40, 32'h180, 1'b1);
      step(); idle_inputs();
      check("sat_ctr11_taken", {31'b0, pred_taken_F}, 32'h1);
      check("hit_target_upd", pred_target_F, 32'h180);
      check("stall_pc_hold", PC_F, 32'h40);
      train(32'h40, 32'h999, 1'b0);
      step();
      check("sat_nt_ctr10", {31'b0, pred_taken_F}, 32'h1);
      check("nt_keeps_target", pred_target_F, 32'h180);
      step(); idle_inputs();
      check("sat_nt_ctr01", {31'b0, pred_taken_F}, 32'h0);
      train(32'h40, 32'h180, 1'b1);
      step(); idle_inputs();
      check("retrain_taken", {31'b0, pred_taken_F}, 32'h1);

      // A not-taken miss must not allocate
      train(32'h20, 32'h300, 1'b0);
      redirect(32'h20);
      step(); idle_inputs();
      check("nt_miss_noalloc", {31'b0, pred_taken_F}, 32'h0);

      // Alias at 0x80 with same index as 0x40
      redirect(32'h80);
      step(); idle_inputs();
      check("alias80_taken", {31'b0, pred_taken_F}, 32'h0);
      check("alias80_target", pred_target_F, 32'h84);

      // Stall for three cycles then redirect while still stalled
      step(); check("stall1", PC_F, 32'h80);
      step(); check("stall2", PC_F, 32'h80);
      step(); check("stall3", PC_F, 32'h80);
      redirect(32'h200);
      step(); idle_inputs();
      check("stall_redirect", PC_F, 32'h200);

      // Fetch follows the prediction when enabled
      enable_fetch = 1'b1;
      redirect(32'h40);
      step(); idle_inputs();
      check("pred_pc_40", PC_F, 32'h40);
      step();
      check("pred_follow_180", PC_F, 32'h180);

      // Wrap-around
      redirect(32'hFFFF_FFFC);
      step(); idle_inputs();
      check("wrap_plus4", PC_plus_4_F, 32'h0);
      check("wrap_target", pred_target_F, 32'h0);
      step();
      check("wrap_pc", PC_F, 32'h0);

      // Asynchronous reset between edges with a valid predicted entry and an in-flight update
      enable_fetch = 1'b0;
      redirect(32'h40);
      step(); idle_inputs();
      check("pre_reset_taken", {31'b0, pred_taken_F}, 32'h1);
      #2;
      async_reset = 1'b0;
      train(32'h40, 32'h500, 1'b1);
      #1;
      check("async_reset_pc", PC_F, 32'h0);
      check("async_reset_target", pred_target_F, 32'h4);
      step(); idle_inputs();
      async_reset = 1'b1;
      redirect(32'h40);
      step(); idle_inputs();
      check("post_reset_pc", PC_F, 32'h40);
      check("post_reset_taken", {31'b0, pred_taken_F}, 32'h0);
      check("post_reset_target", pred_target_F, 32'h44);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
